// File: rtl/ser_pkg.sv
// Shared definitions for the serial link (serializer and deserializer).
// Word width, length-field width, word/length typedefs and the
// IDLE/COLLECT state encoding used on both ends of the link.
package ser_pkg;

    localparam int SER_DATA_W = 16;
    localparam int SER_MOD_W  = $clog2(SER_DATA_W);

    typedef logic [SER_DATA_W-1:0] ser_word_t;
    typedef logic [SER_MOD_W-1:0]  ser_mod_t;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COLLECT = 1'b1
    } ser_state_t;

endpackage

// File: rtl/deserializer.sv
// Serial-to-parallel receiver. Collects an MSB-first bit stream qualified
// by ser_data_val_i into left-aligned words. A word completes either on
// its DATA_W-th bit or on the first idle cycle after a partial word.
// The result is presented with a one-cycle valid pulse.
// Optional macro DESER_MOD_OUT_EN adds the deser_data_mod_o length port
// (0 = full word, otherwise the number of received bits).
module deserializer
    import ser_pkg::*;
#(
    parameter int DATA_W = SER_DATA_W,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
`ifdef DESER_MOD_OUT_EN
    output logic [MOD_W-1:0]  deser_data_mod_o,
`endif
    output logic              deser_data_val_o,
    output logic              busy_o
);

    ser_state_t        state_reg;
    logic [MOD_W-1:0]  cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] word_next;
    logic [DATA_W-1:0] data_reg;
    logic              val_reg;
    logic              busy_reg;
`ifdef DESER_MOD_OUT_EN
    logic [MOD_W-1:0]  mod_reg;
`endif

    // Shift register with the incoming bit dropped into slot DATA_W-1-cnt.
    // DATA_W is a power of two, so that slot index is simply ~cnt_reg.
    // shift_reg is cleared on every completion, so in IDLE this yields
    // {bit, 0...} and unused LSBs of a short word stay zero.
    always_comb begin
        word_next             = shift_reg;
        word_next[~cnt_reg]   = ser_data_i;
    end

    // Receive FSM: bit counting, word assembly and registered outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            val_reg   <= 1'b0;
            busy_reg  <= 1'b0;
`ifdef DESER_MOD_OUT_EN
            mod_reg   <= '0;
`endif
        end else begin
            val_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (ser_data_val_i) begin
                        shift_reg <= word_next;
                        cnt_reg   <= MOD_W'(1);
                        state_reg <= ST_COLLECT;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_COLLECT: begin
                    if (ser_data_val_i) begin
                        if (&cnt_reg) begin
                            // DATA_W-th bit: full word, length field wraps to 0
                            data_reg  <= word_next;
                            val_reg   <= 1'b1;
                            shift_reg <= '0;
                            cnt_reg   <= '0;
                            state_reg <= ST_IDLE;
                            busy_reg  <= 1'b0;
`ifdef DESER_MOD_OUT_EN
                            mod_reg   <= '0;
`endif
                        end else begin
                            shift_reg <= word_next;
                            cnt_reg   <= cnt_reg + MOD_W'(1);
                        end
                    end else begin
                        // Stream paused: whatever is held is a short word
                        data_reg  <= shift_reg;
                        val_reg   <= 1'b1;
                        shift_reg <= '0;
                        cnt_reg   <= '0;
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
`ifdef DESER_MOD_OUT_EN
                        mod_reg   <= cnt_reg;
`endif
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign deser_data_o     = data_reg;
    assign deser_data_val_o = val_reg;
    assign busy_o           = busy_reg;
`ifdef DESER_MOD_OUT_EN
    assign deser_data_mod_o = mod_reg;
`endif

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Downstream stage of the serializer. Converts the MSB-first 1-bit stream plus its valid strobe back into parallel words.
- Reports the received word length in the same data_mod encoding the serializer accepts: 0 = full word, 1..DATA_W-1 = number of bits.
- Sits at the receive side of the serial link and feeds the parallel datapath. Output is a single-cycle valid pulse; there is no backpressure.

Parameters:
- DATA_W, 16, parallel word width; a power of two, >= 4.
- MOD_W, $clog2(DATA_W), width of the length field (4 at default).

Ports:
- clk_i  input  1  clock; all logic on posedge.
- arst_i  input  1  asynchronous active-high reset.
- ser_data_i  input  1  serial data bit, sampled only when ser_data_val_i=1.
- ser_data_val_i  input  1  serial bit valid, one bit per cycle when high.
- deser_data_o  output  DATA_W  received word, left-aligned (first bit in [DATA_W-1]); unused LSBs are 0.
- deser_data_mod_o  output  MOD_W  bit count of the word; 0 means DATA_W bits (present only with DESER_MOD_OUT_EN).
- deser_data_val_o  output  1  one-cycle pulse: deser_data_o (and mod) valid.
- busy_o  output  1  high while a partial word is held (1..DATA_W-1 bits collected).

Behaviour:
- Reset (async assert, released synchronously by the integrator):
  - deser_data_o=0, deser_data_mod_o=0, deser_data_val_o=0, busy_o=0.
  - Bit counter=0, shift register=0, state=IDLE.
- States:
  - IDLE: no bits held.
  - COLLECT: 1..DATA_W-1 bits held.
- IDLE:
  - ser_data_val_i=1 -> store bit at shift[DATA_W-1], cnt=1, go to COLLECT.
  - Otherwise stay in IDLE.
- COLLECT with ser_data_val_i=1:
  - Store bit at shift[DATA_W-1-cnt], cnt++.
  - If this is bit number DATA_W: complete, emit full word, cnt=0, go to IDLE.
- COLLECT with ser_data_val_i=0: complete a short word of cnt bits, cnt=0, go to IDLE.
- Completion (registered outputs):
  - On the next clock, deser_data_val_o=1 for exactly one cycle.
  - deser_data_o = assembled word, unused LSBs forced to 0.
  - mod = cnt mod DATA_W.
- Latency:
  - Full word: valid pulse 1 cycle after the cycle carrying the last bit.
  - Short word: valid pulse 1 cycle after the first idle cycle.
- deser_data_o and mod hold their value until the next completion; they are not cleared when valid drops.
- Back-to-back full words: a new first bit in the cycle after the DATA_W-th bit is accepted normally. A word can start in IDLE on the same cycle the previous word's valid pulse is emitted, with no bubble.
- Framing contract for the upstream side:
  - Short words must be followed by at least 1 idle cycle.
  - Contiguous valid bits are always framed as DATA_W-bit words.
  - An unframed short stream produces DATA_W-bit words plus a trailing short word; this is not an error.
- Single-bit word: val high 1 cycle then low -> word = {bit, 0...}, mod=1.
- Reset mid-word discards partial bits. No valid pulse is produced.
- busy_o = (state==COLLECT), registered. It goes low the same cycle deser_data_val_o pulses.
- ser_data_i is don't-care while ser_data_val_i=0.

Optional Feature:
- DESER_MOD_OUT_EN:
  - Defined: the deser_data_mod_o port exists and is driven as above.
  - Undefined: the port and its register are removed. The length is recoverable only by the consumer's own convention; zero-filled LSBs are unchanged.

Decomposition:
- Shared package ser_pkg:
  - DATA_W default and MOD_W constant.
  - typedef of the data word and the mod field.
  - enum for the IDLE/COLLECT state.
  - The serializer and deserializer both import it.
- No sub-module: the counter, shift register and output register are small enough to stay flat.

Test Plan:
- Full word: 16 contiguous bits of 16'hA5C3 MSB first -> one pulse 1 cycle after the last bit; data=16'hA5C3, mod=0, busy_o high for cycles 1..15.
- Short word: 5 bits 1,0,1,1,0 then val low -> pulse after the idle cycle; data=16'hB000, mod=5.
- Back-to-back: 16'hFFFF then immediately 16'h0001 with no gap -> two pulses 16 cycles apart; data=16'hFFFF then 16'h0001; no bits lost.
- Min word: single bit 1 then idle -> data=16'h8000, mod=1; a second single bit 0 after 1 idle -> data=16'h0000, mod=1.
- Reset mid-word: 7 bits, then arst_i pulsed asynchronously between edges -> outputs 0 immediately, no pulse. A subsequent 16'h1234 is received correctly.
- Loopback: serializer -> deserializer with random data and mod in {0,3..15}, one idle cycle inserted after short words -> every received word equals the sent word masked to its length, with matching mod.
